// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton input stage: per-channel FSM encoding,
// default debounce depth and a small decode helper for the debounced level.
package button_conditioner_pkg;

    // Per-channel debounce FSM; bit 1 set means the debounced level is "pressed"
    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        PRESS_CHK   = 2'b01,
        PRESSED     = 2'b10,
        RELEASE_CHK = 2'b11
    } btn_state_t;

    localparam int DEFAULT_N_BTN           = 4;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_CNT_W           = 5;

    // Debounced level: still pressed while a release is being qualified
    function automatic logic is_stable_pressed(input btn_state_t s);
        return (s == PRESSED) || (s == RELEASE_CHK);
    endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One pushbutton channel: two-flop synchronizer, debounce counter and FSM,
// one-cycle press pulse and a sticky capture bit cleared by the uP read strobe.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    input  logic read_ack,
    output logic stable,
    output logic capture,
    output logic press_event
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    logic             sync1;
    logic             sync2;
    btn_state_t       state;
    btn_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;

    // Bring the asynchronous button into the clock domain; only sync2 is used downstream
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button_raw;
            sync2 <= sync1;
        end
    end

    // FSM state and stability counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= CNT_ZERO;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A change is accepted only after DEBOUNCE_CYCLES consecutive agreeing samples
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (sync2) begin
                    state_next = PRESS_CHK;
                    cnt_next   = CNT_ONE;
                end
            end
            PRESS_CHK: begin
                if (!sync2) begin
                    state_next = IDLE;
                    cnt_next   = CNT_ZERO;
                end else if (cnt == CNT_LIMIT) begin
                    state_next = PRESSED;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync2) begin
                    state_next = RELEASE_CHK;
                    cnt_next   = CNT_ONE;
                end
            end
            RELEASE_CHK: begin
                if (sync2) begin
                    state_next = PRESSED;
                    cnt_next   = CNT_ZERO;
                end else if (cnt == CNT_LIMIT) begin
                    state_next = IDLE;
                    cnt_next   = CNT_ZERO;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // Decode the debounced level and the press-qualification transition
    always_comb begin
        stable = is_stable_pressed(state);
        accept = (state == PRESS_CHK) && sync2 && (cnt == CNT_LIMIT);
    end

    // Press pulse is registered; capture sets from the visible pulse so a read
    // strobe in the same cycle as the pulse can never drop the new press
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            press_event <= 1'b0;
            capture     <= 1'b0;
        end else begin
            press_event <= accept;
            capture     <= (capture & ~read_ack) | press_event;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton input stage for the uP IN port: N_BTN independent debounce
// channels, with a registered level/sticky output mux and a pending flag.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int N_BTN           = DEFAULT_N_BTN,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] buttons_raw,
    input  logic             read_ack,
    input  logic             sticky_mode,
    output logic [N_BTN-1:0] pushbuttons,
    output logic             pending,
    output logic [N_BTN-1:0] press_event
);

    logic [N_BTN-1:0] stable_vec;
    logic [N_BTN-1:0] capture_vec;

    for (genvar i = 0; i < N_BTN; i++) begin : g_channel
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_channel (
            .clock       (clock),
            .reset       (reset),
            .button_raw  (buttons_raw[i]),
            .read_ack    (read_ack),
            .stable      (stable_vec[i]),
            .capture     (capture_vec[i]),
            .press_event (press_event[i])
        );
    end

    // Register the mode-selected view and the pending flag so the uP sees clean flops
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pushbuttons <= '0;
            pending     <= 1'b0;
        end else begin
            pushbuttons <= sticky_mode ? capture_vec : stable_vec;
            pending     <= |capture_vec;
        end
    end

endmodule
